// File: rtl/digital_lock_pkg.sv
// Shared state encoding and width helpers for the multi-code keypad lock.
package digital_lock_pkg;

    localparam int unsigned STATE_BITS = 3;

    typedef enum logic [STATE_BITS-1:0] {
        ST_LOCKED   = 3'd0,
        ST_CHECK    = 3'd1,
        ST_UNLOCKED = 3'd2,
        ST_NEW_CODE = 3'd3,
        ST_CONFIRM  = 3'd4,
        ST_LOCKOUT  = 3'd5
    } lock_state_t;

    // Bits needed to hold 0..max_value; never narrower than one bit.
    function automatic int unsigned counter_width(input int unsigned max_value);
        return (max_value < 1) ? 1 : $clog2(max_value + 1);
    endfunction

    function automatic int unsigned digit_width(input int unsigned lines);
        return (lines < 2) ? 1 : $clog2(lines);
    endfunction

endpackage

// File: rtl/digital_lock_multi_key_press_decoder.sv
// Keypad edge detector: one registered press pulse per clean one-hot press, with its index.
module key_press_decoder
    import digital_lock_pkg::*;
#(
    parameter int unsigned KEY_WIDTH  = 4,
    parameter int unsigned DIGIT_BITS = digit_width(KEY_WIDTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [KEY_WIDTH-1:0]  key,
    output logic                  press_valid,
    output logic [DIGIT_BITS-1:0] digit
);

    logic [KEY_WIDTH-1:0]  prev_key;
    logic                  one_hot;
    logic [DIGIT_BITS-1:0] index;

    always_comb begin
        one_hot = (key != '0) && ((key & (key - KEY_WIDTH'(1))) == '0);
        index   = '0;
        for (int unsigned i = 0; i < KEY_WIDTH; i++) begin
            if (key[i]) begin
                index = DIGIT_BITS'(i);
            end
        end
    end

    // A press only counts when the previous sample was fully released.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_key    <= '0;
            press_valid <= 1'b0;
            digit       <= '0;
        end else begin
            prev_key    <= key;
            press_valid <= one_hot && (prev_key == '0);
            if (one_hot && (prev_key == '0)) begin
                digit <= index;
            end
        end
    end

endmodule

// File: rtl/digital_lock_multi.sv
// Keypad lock with lockout after repeated failures, idle auto-relock and confirmed code change.
module digital_lock_multi
    import digital_lock_pkg::*;
#(
    parameter int unsigned KEY_WIDTH       = 4,
    parameter int unsigned PASSCODE_LENGTH = 4,
    parameter logic [PASSCODE_LENGTH*digit_width(KEY_WIDTH)-1:0] DEFAULT_CODE = 8'hEC,
    parameter int unsigned MAX_ATTEMPTS    = 3,
    parameter int unsigned LOCKOUT_CYCLES  = 16,
    parameter int unsigned UNLOCK_TIMEOUT  = 32
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic [KEY_WIDTH-1:0]                      key,
    input  logic                                      lock_req,
    input  logic                                      change_req,
    output logic                                      locked,
    output logic                                      error,
    output logic                                      lockout,
    output logic                                      code_changed,
    output logic [counter_width(PASSCODE_LENGTH)-1:0] entry_count,
    output logic [counter_width(MAX_ATTEMPTS)-1:0]    fail_count,
    output logic [STATE_BITS-1:0]                     state
);

    localparam int unsigned DIGIT_BITS   = digit_width(KEY_WIDTH);
    localparam int unsigned CODE_BITS    = PASSCODE_LENGTH * DIGIT_BITS;
    localparam int unsigned ENTRY_BITS   = counter_width(PASSCODE_LENGTH);
    localparam int unsigned FAIL_BITS    = counter_width(MAX_ATTEMPTS);
    localparam int unsigned LOCKOUT_BITS = counter_width(LOCKOUT_CYCLES);
    localparam int unsigned IDLE_BITS    = counter_width(UNLOCK_TIMEOUT);

    localparam logic [ENTRY_BITS-1:0]   LAST_DIGIT   = ENTRY_BITS'(PASSCODE_LENGTH - 1);
    localparam logic [FAIL_BITS-1:0]    FAIL_MAX     = FAIL_BITS'(MAX_ATTEMPTS);
    localparam logic [LOCKOUT_BITS-1:0] LOCKOUT_LAST = LOCKOUT_BITS'(LOCKOUT_CYCLES - 1);
    localparam logic [IDLE_BITS-1:0]    IDLE_LAST    =
        IDLE_BITS'((UNLOCK_TIMEOUT == 0) ? 0 : UNLOCK_TIMEOUT - 1);

    lock_state_t              st;
    logic                     press_valid;
    logic [DIGIT_BITS-1:0]    digit;
    logic [CODE_BITS-1:0]     code;
    logic [CODE_BITS-1:0]     entry_buf;
    logic [CODE_BITS-1:0]     new_buf;
    logic [CODE_BITS-1:0]     entry_next;
    logic [CODE_BITS-1:0]     new_next;
    logic [FAIL_BITS-1:0]     fail_next;
    logic [LOCKOUT_BITS-1:0]  lockout_cnt;
    logic [IDLE_BITS-1:0]     idle_cnt;

    key_press_decoder #(
        .KEY_WIDTH  (KEY_WIDTH),
        .DIGIT_BITS (DIGIT_BITS)
    ) u_decoder (
        .clock       (clock),
        .reset       (reset),
        .key         (key),
        .press_valid (press_valid),
        .digit       (digit)
    );

    // Shift-based append keeps PASSCODE_LENGTH == 1 free of empty part-selects.
    always_comb begin
        entry_next = (entry_buf << DIGIT_BITS) | CODE_BITS'(digit);
        new_next   = (new_buf << DIGIT_BITS) | CODE_BITS'(digit);
        fail_next  = (fail_count == FAIL_MAX) ? fail_count : fail_count + FAIL_BITS'(1);
    end

    assign state = st;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st           <= ST_LOCKED;
            locked       <= 1'b1;
            error        <= 1'b0;
            lockout      <= 1'b0;
            code_changed <= 1'b0;
            entry_count  <= '0;
            fail_count   <= '0;
            code         <= DEFAULT_CODE;
            entry_buf    <= '0;
            new_buf      <= '0;
            lockout_cnt  <= '0;
            idle_cnt     <= '0;
        end else begin
            error        <= 1'b0;
            code_changed <= 1'b0;
            case (st)
                ST_LOCKED: begin
                    if (press_valid) begin
                        entry_buf   <= entry_next;
                        entry_count <= entry_count + ENTRY_BITS'(1);
                        if (entry_count == LAST_DIGIT) begin
                            st <= ST_CHECK;
                        end
                    end
                end

                ST_CHECK: begin
                    entry_count <= '0;
                    entry_buf   <= '0;
                    if (entry_buf == code) begin
                        st         <= ST_UNLOCKED;
                        locked     <= 1'b0;
                        fail_count <= '0;
                        idle_cnt   <= '0;
                    end else begin
                        error      <= 1'b1;
                        fail_count <= fail_next;
                        if (fail_next == FAIL_MAX) begin
                            st          <= ST_LOCKOUT;
                            lockout     <= 1'b1;
                            lockout_cnt <= '0;
                        end else begin
                            st <= ST_LOCKED;
                        end
                    end
                end

                ST_LOCKOUT: begin
                    if (lockout_cnt == LOCKOUT_LAST) begin
                        st         <= ST_LOCKED;
                        lockout    <= 1'b0;
                        fail_count <= '0;
                    end else begin
                        lockout_cnt <= lockout_cnt + LOCKOUT_BITS'(1);
                    end
                end

                ST_UNLOCKED: begin
                    if (lock_req) begin
                        st          <= ST_LOCKED;
                        locked      <= 1'b1;
                        entry_count <= '0;
                        entry_buf   <= '0;
                        new_buf     <= '0;
                    end else if (change_req) begin
                        st          <= ST_NEW_CODE;
                        entry_count <= '0;
                        entry_buf   <= '0;
                        new_buf     <= '0;
                    end else if (press_valid) begin
                        idle_cnt <= '0;
                    end else if (UNLOCK_TIMEOUT != 0) begin
                        if (idle_cnt == IDLE_LAST) begin
                            st          <= ST_LOCKED;
                            locked      <= 1'b1;
                            entry_count <= '0;
                            entry_buf   <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + IDLE_BITS'(1);
                        end
                    end
                end

                ST_NEW_CODE: begin
                    if (lock_req) begin
                        st          <= ST_LOCKED;
                        locked      <= 1'b1;
                        entry_count <= '0;
                        entry_buf   <= '0;
                        new_buf     <= '0;
                    end else if (press_valid) begin
                        new_buf <= new_next;
                        if (entry_count == LAST_DIGIT) begin
                            st          <= ST_CONFIRM;
                            entry_count <= '0;
                            entry_buf   <= '0;
                        end else begin
                            entry_count <= entry_count + ENTRY_BITS'(1);
                        end
                    end
                end

                ST_CONFIRM: begin
                    if (lock_req) begin
                        st          <= ST_LOCKED;
                        locked      <= 1'b1;
                        entry_count <= '0;
                        entry_buf   <= '0;
                        new_buf     <= '0;
                    end else if (press_valid) begin
                        if (entry_count == LAST_DIGIT) begin
                            // Compare including the digit arriving this cycle.
                            if (entry_next == new_buf) begin
                                code         <= new_buf;
                                code_changed <= 1'b1;
                            end else begin
                                error <= 1'b1;
                            end
                            st          <= ST_UNLOCKED;
                            idle_cnt    <= '0;
                            entry_count <= '0;
                            entry_buf   <= '0;
                            new_buf     <= '0;
                        end else begin
                            entry_buf   <= entry_next;
                            entry_count <= entry_count + ENTRY_BITS'(1);
                        end
                    end
                end

                default: begin
                    st     <= ST_LOCKED;
                    locked <= 1'b1;
                end
            endcase
        end
    end

endmodule
